bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter that turns a binary score or count into four decimal digits.
- Uses shift-and-add-3 (double dabble), one bit per clock.
- Sits upstream of the four-digit seven-segment display driver and feeds its ones/tens/hundreds/thousands inputs.
- Results are registered and held between conversions, so the display never shows intermediate values.

---
 rtl/bin2bcd_seq.sv | 85 ++++++++
 tb/tb_bin2bcd_seq.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock,
// with the input clamped to MAX_VAL and four registered, held digit outputs.
module bin2bcd_seq #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands
);
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_B = BIN_W'(MAX_VAL);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [15:0]      dig_q, dig_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  // add-3 correction on every nibble, applied before the shift
  for (genvar g = 0; g < 4; g++) begin : g_adj
    assign bcd_adj[4*g +: 4] = (bcd_q[4*g +: 4] >= 4'd5) ? bcd_q[4*g +: 4] + 4'd3 : bcd_q[4*g +: 4];
  end
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (state_q == IDLE && start) begin
      bin_d   = (bin > MAX_B) ? MAX_B : bin;
      pend_d  = bin > MAX_B;
      bcd_d   = '0;
      cnt_d   = CW'(BIN_W);
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
      cnt_d   = cnt_q - CW'(1);
      state_d = (cnt_q == CW'(1)) ? DONE : SHIFT;
    end else if (state_q == DONE) begin
      dig_d   = bcd_q;
      ovf_d   = pend_q;
      done_d  = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign {thousands, hundreds, tens, ones} = dig_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed bench with a decimal reference model and a result scoreboard.
module tb_bin2bcd_seq;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [13:0] bin = '0;
  logic        busy, done, overflow;
  logic [3:0]  ones, tens, hundreds, thousands;
  logic [16:0] q[$];
  int nchk = 0, nerr = 0, cyc = 0, last_done = -1, lat;
  bit sweep = 0;

  bin2bcd_seq dut (
    .clk_100MHz(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .overflow(overflow),
    .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] model(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {(v > 9999) ? 1'b1 : 1'b0, 4'(c / 1000), 4'(c / 100 % 10), 4'(c / 10 % 10), 4'(c % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {overflow, thousands, hundreds, tens, ones};
  endfunction

  // scoreboard: every done must match the oldest outstanding request
  always @(negedge clk) begin
    if (done === 1'b1) begin
      check("result", 32'(outs()), (q.size() != 0) ? 32'(q.pop_front()) : 32'h1ffff);
      if (sweep && last_done >= 0) check("done_period", cyc - last_done, 16);
      last_done = cyc;
    end
  end

  task automatic start_conv(input int v);
    @(negedge clk);
    bin = 14'(v);
    start = 1'b1;
    q.push_back(model(v));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int k);
    for (k = 1; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) break;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() != 0; k++) @(negedge clk);
    check("drain", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #23;
    check("reset_outs", {busy, done, outs()}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {busy, done, outs()}, 0);
    start_conv(0);
    check("busy_high", busy, 1);
    wait_done(lat);
    check("latency", lat, 15);
    drain();
    start_conv(1234);
    wait_done(lat);
    @(posedge clk);
    #1 check("done_width", done, 0);
    drain();
    bin = 14'd5555;
    repeat (20) @(negedge clk);
    check("hold_1234", {done, outs()}, {1'b0, model(1234)});
    start_conv(9999);    drain();
    start_conv(10000);   drain();
    start_conv(16383);   drain();
    start_conv(7);
    repeat (6) @(negedge clk);
    check("ovf_held", overflow, 1);
    drain();
    check("ovf_cleared", overflow, 0);
    start_conv(4321);
    repeat (4) @(posedge clk);
    #1 begin bin = 14'd1111; start = 1'b1; end
    @(posedge clk);
    #1 start = 1'b0;
    drain();
    repeat (30) @(negedge clk);
    check("single_done", outs(), model(4321));
    start_conv(1234); drain();
    start_conv(8765);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("async_reset", {busy, done, outs()}, 0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("no_done_after_abort", {busy, outs()}, 0);
    start_conv(42); drain();
    last_done = -1;
    sweep = 1;
    for (int v = 0; v <= 10000; v += 101) begin
      bin = 14'((v > 9999) ? 9999 : v);
      start = 1'b1;
      q.push_back(model(int'(bin)));
      repeat (16) @(negedge clk);
    end
    start = 1'b0;
    drain();
    sweep = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
